fifo_reader: RTL
================

// Module: fifo_reader
// PURPOSE
//  Read-side master for the team's shared FIFO (rd/rdata/empty handshake, registered rdata).
//  Drains the FIFO and re-presents words downstream on a valid/ready stream at 1 word/cycle.
//  Hides the FIFO's one-cycle read latency and its rule that rd is ignored when wr is
//  asserted in the same cycle. Sits between fifo and any streaming consumer.
// PARAMETERS
//  DW     4   data width; must match the FIFO word width
//  CNT_W  16  width of rd_count (only with FIFO_RD_STATS_EN)
// PORTS
//  clk         in   1      system clock; all logic on posedge
//  rst         in   1      asynchronous, active-high reset
//  fifo_empty  in   1      FIFO empty flag
//  fifo_wr     in   1      monitor of the writer's wr into the same FIFO
//  fifo_rdata  in   DW     FIFO read data; valid the cycle after an accepted read
//  fifo_rd     out  1      read request to the FIFO
//  out_valid   out  1      out_data holds a word
//  out_ready   in   1      consumer accepts the word when out_valid&&out_ready
//  out_data    out  DW     head word of the output buffer
//  rd_count    out  CNT_W  words delivered (FIFO_RD_STATS_EN only)
// BEHAVIOUR
//  - Reset (async, rst=1): occ=0, pend=0, buffer=0, out_valid=0, out_data=0, fifo_rd=0,
//    rd_count=0. Any in-flight word is discarded. No read is issued while rst=1.
//  - State: occ (0..2, words in the 2-entry output buffer) and pend (a read was accepted
//    last cycle; its data is on fifo_rdata this cycle).
//  - pop = out_valid && out_ready.
//  - fifo_rd is combinational: !fifo_empty && !fifo_wr && (occ + pend - pop < 2).
//    fifo_wr=1 suppresses fifo_rd because the FIFO performs neither operation on {rd,wr}=11.
//  - Accepted read: pend <= fifo_rd at the clock edge.
//  - If pend=1, fifo_rdata is written into the buffer tail at the edge.
//  - Buffer order is FIFO order: head is the oldest word.
//  - Occupancy update: occ_next = occ + pend - pop. Push and pop in the same cycle is legal.
//    When occ=0 and pend=1, the word written is the new head.
//  - out_valid = (occ != 0). out_data = head. Both are registered and stable while
//    out_valid=1 and out_ready=0.
//  - Latency: fifo_rd issued in cycle N produces out_valid in cycle N+2.
//    Steady-state throughput is 1 word/cycle when out_ready=1 and the FIFO is non-empty.
//  - Backpressure: with out_ready=0, at most 2 words are outstanding (occ + pend <= 2),
//    so no word is lost. fifo_rd=0 while occ + pend = 2.
//  - fifo_empty=1: no read is issued; buffered words still drain.
//  - Invariant: the combination occ=2 && pend=1 never occurs. A checker asserts this.
//  - Reset mid-stream: the buffer and pend are cleared immediately. The FIFO is reset on the
//    same rst, so no data-consistency requirement applies across a reset.
// CONFIGURATION
//  FIFO_RD_STATS_EN defined:
//   - rd_count port exists.
//   - rd_count increments on each pop and saturates at 2**CNT_W-1.
//  FIFO_RD_STATS_EN undefined:
//   - rd_count port and counter are absent.
//   - All other behaviour is identical.
// STRUCTURE
//  - fifo_rd_pkg:
//    - DW_DEFAULT=4, FIFO_DEPTH=5
//    - typedef logic [1:0] occ_t
//    - function can_issue(occ, pend, pop)
//  - Sub-module fifo_rd_skid: 2-entry buffer (push, push_data, pop, occ, head). Holds all
//    storage; fifo_reader keeps pend, issue logic and the stats counter.
// TESTING
//  1. Reset with FIFO holding 3,7,9; release rst; out_ready=1 ->
//     - fifo_rd rises in cycle 1;
//     - out_data 3,7,9 appears on consecutive cycles from cycle 3;
//     - then out_valid=0.
//  2. FIFO holds 5 words, out_ready=0 ->
//     - exactly 2 reads issued; occ=2; fifo_rd stays 0;
//     - raise out_ready: all 5 words delivered in order, 1 per cycle after refill.
//  3. Writer asserts fifo_wr for 3 cycles while FIFO non-empty ->
//     - fifo_rd=0 in those cycles; no word lost or duplicated;
//     - order preserved (e.g. A,B then C written during the stall).
//  4. Toggle out_ready 1010... with a continuous FIFO supply ->
//     - out_data held stable whenever out_valid && !out_ready;
//     - sequence 0..15 delivered exactly once.
//  5. Assert rst while pend=1 and occ=1 ->
//     - out_valid=0 and out_data=0 immediately (async);
//     - first post-reset word is the first word written after reset.
//  6. FIFO_RD_STATS_EN: deliver 20 words -> rd_count=20.
//     With CNT_W=4 and 20 words -> rd_count saturates at 15.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side master (fifo_reader).
package fifo_rd_pkg;

    localparam int DW_DEFAULT = 4;
    localparam int FIFO_DEPTH = 5;

    // Words held in the 2-entry output buffer (0..2)
    typedef logic [1:0] occ_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // A new read may be issued only if the buffer can still absorb its word
    // next cycle: words held + word arriving - word leaving must stay below 2.
    function automatic logic can_issue(input occ_t occ, input logic pend, input logic pop);
        logic [2:0] w_sum;
        w_sum = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
        return (w_sum < 3'd2);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer for fifo_reader. Holds all word storage;
// head is the oldest word and is presented directly as the output data.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output occ_t          o_occ,
    output logic [DW-1:0] o_head
);

    occ_e          r_occ;
    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    occ_t          w_occ_nxt;

    // Next occupancy: a push and a pop in the same cycle cancel out
    always_comb begin
        w_occ_nxt = occ_t'(r_occ) + {1'b0, i_push} - {1'b0, i_pop};
    end

    // Storage update; an empty buffer takes the pushed word straight into the head
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_occ  <= OCC_EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_occ <= occ_e'(w_occ_nxt);
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == OCC_EMPTY) r_head <= i_push_data;
                    else                    r_tail <= i_push_data;
                end
                2'b01: begin
                    // With one word left the shifted-in tail is stale but unseen
                    r_head <= r_tail;
                end
                2'b11: begin
                    if (r_occ == OCC_ONE) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_occ  = occ_t'(r_occ);
    assign o_head = r_head;

endmodule

// File: rtl/fifo_reader.sv
// Read-side master for the shared FIFO: drains it through the rd/rdata/empty
// handshake and re-presents the words on a valid/ready stream at 1 word/cycle.
// Optional build macro FIFO_RD_STATS_EN adds the o_rd_count delivered-word counter.
module fifo_reader
    import fifo_rd_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fifo_empty,
    input  logic             i_fifo_wr,
    input  logic [DW-1:0]    i_fifo_rdata,
    output logic             o_fifo_rd,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [DW-1:0]    o_out_data
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_W-1:0] o_rd_count
`endif
);

    if (DW < 1) begin : g_bad_dw
        $error("fifo_reader: DW must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("fifo_reader: CNT_W must be >= 1");
    end

    logic          r_pend;   // read accepted last cycle; its word is on i_fifo_rdata now
    occ_t          w_occ;
    logic [DW-1:0] w_head;
    logic          w_pop;
    logic          w_rd;

    assign w_pop = o_out_valid && i_out_ready;

    // The FIFO ignores rd when wr is high in the same cycle, so never issue
    // then; and never issue while held in reset.
    always_comb begin
        w_rd = !i_rst && !i_fifo_empty && !i_fifo_wr && can_issue(w_occ, r_pend, w_pop);
    end

    // Track the one-cycle read latency of the FIFO
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_pend <= 1'b0;
        else       r_pend <= w_rd;
    end

    fifo_rd_skid #(
        .DW (DW)
    ) u_skid (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_pend),
        .i_push_data (i_fifo_rdata),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    assign o_fifo_rd   = w_rd;
    assign o_out_valid = (w_occ != 2'd0);
    assign o_out_data  = w_head;

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] r_rd_count;

    // Count delivered words, holding at the maximum value
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_rd_count <= '0;
        else if (w_pop && (r_rd_count != {CNT_W{1'b1}}))
            r_rd_count <= r_rd_count + CNT_W'(1);
    end

    assign o_rd_count = r_rd_count;
`endif

    // A full buffer with a word still in flight would drop that word
    always @(posedge i_clk) begin
        if (!i_rst) a_no_overflow: assert (!((w_occ == 2'd2) && r_pend));
    end

endmodule
